issue_queue: RTL and testbench

Parametrised reservation station replacing the fixed 2-in/2-ALU dispatch/issue block. Accepts up to DISPATCH_WIDTH renamed ops per cycle and captures operand values from WB_WIDTH writeback broadcast ports. Selects up to ISSUE_WIDTH ready ops per cycle toward ALU FUs using a valid/ready handshake. Sits between rename/ROB allocation and the ALU execute stage.

---
 rtl/issue_queue_if.sv | 58 +++++
 rtl/issue_queue.sv | 279 +++++++++++++++++++++++++++
 tb/tb_issue_queue.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_if.sv
// issue_queue_if: dispatch, writeback-broadcast and issue bundle for the ALU issue queue.
// Latency: none (wires only).
// Backpressure: disp_ready_o gates the dispatch slots; iss_ready_i holds each issue port.
interface issue_queue_if #(
  parameter int WORD_SIZE      = 32,
  parameter int NUM_P_REGS     = 64,
  parameter int ROB_SIZE       = 64,
  parameter int ALU_OP_SIZE    = 4,
  parameter int DISPATCH_WIDTH = 2,
  parameter int ISSUE_WIDTH    = 2,
  parameter int WB_WIDTH       = 3
);
  localparam int PT = $clog2(NUM_P_REGS);
  localparam int RB = $clog2(ROB_SIZE);

  // dispatch side (rename / ROB allocation)
  logic [DISPATCH_WIDTH-1:0]             disp_valid_i;
  logic                                  disp_ready_o;
  logic [DISPATCH_WIDTH*PT-1:0]          disp_dest_i;
  logic [DISPATCH_WIDTH*PT-1:0]          disp_rs1_i;
  logic [DISPATCH_WIDTH*PT-1:0]          disp_rs2_i;
  logic [DISPATCH_WIDTH-1:0]             disp_rs1_rdy_i;
  logic [DISPATCH_WIDTH-1:0]             disp_rs2_rdy_i;
  logic [DISPATCH_WIDTH*WORD_SIZE-1:0]   disp_rs1_val_i;
  logic [DISPATCH_WIDTH*WORD_SIZE-1:0]   disp_rs2_val_i;
  logic [DISPATCH_WIDTH*WORD_SIZE-1:0]   disp_imm_i;
  logic [DISPATCH_WIDTH-1:0]             disp_use_imm_i;
  logic [DISPATCH_WIDTH*ALU_OP_SIZE-1:0] disp_alu_op_i;
  logic [DISPATCH_WIDTH*RB-1:0]          disp_rob_idx_i;

  // writeback broadcast
  logic [WB_WIDTH-1:0]                   wb_valid_i;
  logic [WB_WIDTH*PT-1:0]                wb_tag_i;
  logic [WB_WIDTH*WORD_SIZE-1:0]         wb_val_i;

  // issue side (ALU functional units)
  logic [ISSUE_WIDTH-1:0]                iss_valid_o;
  logic [ISSUE_WIDTH-1:0]                iss_ready_i;
  logic [ISSUE_WIDTH*WORD_SIZE-1:0]      iss_data0_o;
  logic [ISSUE_WIDTH*WORD_SIZE-1:0]      iss_data1_o;
  logic [ISSUE_WIDTH*ALU_OP_SIZE-1:0]    iss_alu_op_o;
  logic [ISSUE_WIDTH*PT-1:0]             iss_dest_o;
  logic [ISSUE_WIDTH*RB-1:0]             iss_rob_idx_o;

  modport master (
    output disp_valid_i, disp_dest_i, disp_rs1_i, disp_rs2_i, disp_rs1_rdy_i, disp_rs2_rdy_i,
           disp_rs1_val_i, disp_rs2_val_i, disp_imm_i, disp_use_imm_i, disp_alu_op_i, disp_rob_idx_i,
           wb_valid_i, wb_tag_i, wb_val_i, iss_ready_i,
    input  disp_ready_o, iss_valid_o, iss_data0_o, iss_data1_o, iss_alu_op_o, iss_dest_o, iss_rob_idx_o
  );

  modport slave (
    input  disp_valid_i, disp_dest_i, disp_rs1_i, disp_rs2_i, disp_rs1_rdy_i, disp_rs2_rdy_i,
           disp_rs1_val_i, disp_rs2_val_i, disp_imm_i, disp_use_imm_i, disp_alu_op_i, disp_rob_idx_i,
           wb_valid_i, wb_tag_i, wb_val_i, iss_ready_i,
    output disp_ready_o, iss_valid_o, iss_data0_o, iss_data1_o, iss_alu_op_o, iss_dest_o, iss_rob_idx_o
  );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: ALU reservation station capturing operands from writeback and selecting ready ops.
// Latency: dispatch-to-issue 1 cycle, writeback-to-issue 1 cycle.
// Backpressure: disp_ready_o low when < DISPATCH_WIDTH free entries; issued ops held until iss_ready_i.
// Optional: define AGE_SELECT_EN for oldest-first select (default: lowest entry index first).
module issue_queue #(
  parameter int WORD_SIZE      = 32,
  parameter int NUM_P_REGS     = 64,
  parameter int ROB_SIZE       = 64,
  parameter int ALU_OP_SIZE    = 4,
  parameter int RS_DEPTH       = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int ISSUE_WIDTH    = 2,
  parameter int WB_WIDTH       = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  issue_queue_if.slave              iq,
  output logic [$clog2(RS_DEPTH):0] count_o,
  output logic                      full_o
);
  localparam int PT = $clog2(NUM_P_REGS);
  localparam int RB = $clog2(ROB_SIZE);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = IW + 1;

  // With use_imm the immediate is stored as an already-ready second source,
  // so select and issue never need to look at the flag again.
  typedef struct packed {
    logic                   valid;
    logic [PT-1:0]          dest;
    logic [PT-1:0]          rs1_tag;
    logic                   rs1_rdy;
    logic [WORD_SIZE-1:0]   rs1_val;
    logic [PT-1:0]          rs2_tag;
    logic                   rs2_rdy;
    logic [WORD_SIZE-1:0]   rs2_val;
    logic [ALU_OP_SIZE-1:0] alu_op;
    logic [RB-1:0]          rob_idx;
`ifdef AGE_SELECT_EN
    logic [CW-1:0]          age;
`endif
  } entry_t;

  typedef struct packed {
    logic                 rdy;
    logic [WORD_SIZE-1:0] val;
  } src_t;

  // Returns the source after snooping the broadcast ports; the lowest matching port wins.
  function automatic src_t snoop(
    input logic [PT-1:0]             tag,
    input logic                      rdy,
    input logic [WORD_SIZE-1:0]      val,
    input logic [WB_WIDTH-1:0]       wv,
    input logic [WB_WIDTH*PT-1:0]    wt,
    input logic [WB_WIDTH*WORD_SIZE-1:0] wd
  );
    src_t r;
    r.rdy = rdy;
    r.val = val;
    if (!rdy) begin
      for (int w = WB_WIDTH - 1; w >= 0; w--) begin
        if (wv[w] && (wt[w*PT +: PT] == tag)) begin
          r.rdy = 1'b1;
          r.val = wd[w*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
    return r;
  endfunction

  entry_t                 ent_q [RS_DEPTH];
  entry_t                 ent_d [RS_DEPTH];
  entry_t                 disp_ent [DISPATCH_WIDTH];
  logic [CW-1:0]          count_q;
  logic                   disp_ready;
  logic [DISPATCH_WIDTH-1:0] disp_acc;
  logic [IW-1:0]          disp_idx [DISPATCH_WIDTH];
  logic [RS_DEPTH-1:0]    elig;
  logic [ISSUE_WIDTH-1:0] sel_vld;
  logic [IW-1:0]          sel_idx [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] iss_fire;
  logic [CW-1:0]          acc_n;
  logic [CW-1:0]          fire_n;
`ifdef AGE_SELECT_EN
  logic [CW-1:0]          age_ctr_q;
`endif

  // Dispatch admission depends on registered occupancy only.
  assign disp_ready      = (count_q <= CW'(RS_DEPTH - DISPATCH_WIDTH));
  assign iq.disp_ready_o = disp_ready;
  assign count_o         = count_q;
  assign full_o          = (count_q == CW'(RS_DEPTH));
  assign iss_fire        = iq.iss_valid_o & iq.iss_ready_i;

  // Build the entry image of each dispatch slot, including same-cycle wakeup.
  always_comb begin
    src_t s1;
    src_t s2;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      s1 = snoop(iq.disp_rs1_i[s*PT +: PT], iq.disp_rs1_rdy_i[s],
                 iq.disp_rs1_val_i[s*WORD_SIZE +: WORD_SIZE],
                 iq.wb_valid_i, iq.wb_tag_i, iq.wb_val_i);
      s2 = snoop(iq.disp_rs2_i[s*PT +: PT], iq.disp_rs2_rdy_i[s],
                 iq.disp_rs2_val_i[s*WORD_SIZE +: WORD_SIZE],
                 iq.wb_valid_i, iq.wb_tag_i, iq.wb_val_i);
      if (iq.disp_use_imm_i[s]) begin
        s2.rdy = 1'b1;
        s2.val = iq.disp_imm_i[s*WORD_SIZE +: WORD_SIZE];
      end
      disp_ent[s]         = '0;
      disp_ent[s].valid   = 1'b1;
      disp_ent[s].dest    = iq.disp_dest_i[s*PT +: PT];
      disp_ent[s].rs1_tag = iq.disp_rs1_i[s*PT +: PT];
      disp_ent[s].rs1_rdy = s1.rdy;
      disp_ent[s].rs1_val = s1.val;
      disp_ent[s].rs2_tag = iq.disp_rs2_i[s*PT +: PT];
      disp_ent[s].rs2_rdy = s2.rdy;
      disp_ent[s].rs2_val = s2.val;
      disp_ent[s].alu_op  = iq.disp_alu_op_i[s*ALU_OP_SIZE +: ALU_OP_SIZE];
      disp_ent[s].rob_idx = iq.disp_rob_idx_i[s*RB +: RB];
    end
  end

  // Allocate accepted slots to the lowest free entries, slot 0 taking the lowest.
  // Freedom is judged on registered valid, so an entry issuing this cycle is not reused yet.
  always_comb begin
    logic [RS_DEPTH-1:0] taken;
    logic                found;
    taken = '0;
    found = 1'b0;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      disp_acc[s] = iq.disp_valid_i[s] & disp_ready & ~flush_i;
      disp_idx[s] = '0;
      found       = 1'b0;
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (disp_acc[s] && !found && !ent_q[e].valid && !taken[e]) begin
          found       = 1'b1;
          disp_idx[s] = IW'(e);
        end
      end
      if (found) taken[disp_idx[s]] = 1'b1;
    end
  end

  // An entry may issue once both operands are held.
  always_comb begin
    for (int e = 0; e < RS_DEPTH; e++) begin
      elig[e] = ent_q[e].valid & ent_q[e].rs1_rdy & ent_q[e].rs2_rdy;
    end
  end

  // Pick up to ISSUE_WIDTH distinct eligible entries in priority order, port 0 first.
  always_comb begin
    logic [RS_DEPTH-1:0] picked;
`ifdef AGE_SELECT_EN
    logic [CW-1:0] rel;
    logic [CW-1:0] best;
    rel  = '0;
    best = '0;
`endif
    picked = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      sel_vld[p] = 1'b0;
      sel_idx[p] = '0;
`ifdef AGE_SELECT_EN
      best = '0;
`endif
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (elig[e] && !picked[e]) begin
`ifdef AGE_SELECT_EN
          // Distance back from the dispatch counter: larger means older, wrap-safe.
          rel = age_ctr_q - ent_q[e].age;
          if (!sel_vld[p] || (rel > best)) begin
            sel_vld[p] = 1'b1;
            sel_idx[p] = IW'(e);
            best       = rel;
          end
`else
          if (!sel_vld[p]) begin
            sel_vld[p] = 1'b1;
            sel_idx[p] = IW'(e);
          end
`endif
        end
      end
      if (sel_vld[p]) picked[sel_idx[p]] = 1'b1;
    end
  end

  // Drive issue ports; payload is zero whenever a port is idle or a flush is in progress.
  always_comb begin
    iq.iss_valid_o   = '0;
    iq.iss_data0_o   = '0;
    iq.iss_data1_o   = '0;
    iq.iss_alu_op_o  = '0;
    iq.iss_dest_o    = '0;
    iq.iss_rob_idx_o = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      if (sel_vld[p] && !flush_i) begin
        iq.iss_valid_o[p]                              = 1'b1;
        iq.iss_data0_o[p*WORD_SIZE +: WORD_SIZE]       = ent_q[sel_idx[p]].rs1_val;
        iq.iss_data1_o[p*WORD_SIZE +: WORD_SIZE]       = ent_q[sel_idx[p]].rs2_val;
        iq.iss_alu_op_o[p*ALU_OP_SIZE +: ALU_OP_SIZE]  = ent_q[sel_idx[p]].alu_op;
        iq.iss_dest_o[p*PT +: PT]                      = ent_q[sel_idx[p]].dest;
        iq.iss_rob_idx_o[p*RB +: RB]                   = ent_q[sel_idx[p]].rob_idx;
      end
    end
  end

  // Count accepted dispatches and completed issue handshakes for the occupancy counter.
  always_comb begin
    acc_n  = '0;
    fire_n = '0;
    for (int s = 0; s < DISPATCH_WIDTH; s++) acc_n = acc_n + CW'(disp_acc[s]);
    for (int p = 0; p < ISSUE_WIDTH; p++) fire_n = fire_n + CW'(iss_fire[p]);
  end

  // Next entry state: wakeup, then issue release, then dispatch fill; flush overrides all.
  always_comb begin
    src_t w1;
    src_t w2;
`ifdef AGE_SELECT_EN
    logic [CW-1:0] stamp;
    stamp = age_ctr_q;
`endif
    for (int e = 0; e < RS_DEPTH; e++) begin
      ent_d[e] = ent_q[e];
      w1 = snoop(ent_q[e].rs1_tag, ent_q[e].rs1_rdy, ent_q[e].rs1_val,
                 iq.wb_valid_i, iq.wb_tag_i, iq.wb_val_i);
      w2 = snoop(ent_q[e].rs2_tag, ent_q[e].rs2_rdy, ent_q[e].rs2_val,
                 iq.wb_valid_i, iq.wb_tag_i, iq.wb_val_i);
      if (ent_q[e].valid) begin
        ent_d[e].rs1_rdy = w1.rdy;
        ent_d[e].rs1_val = w1.val;
        ent_d[e].rs2_rdy = w2.rdy;
        ent_d[e].rs2_val = w2.val;
      end
    end
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      if (iss_fire[p]) ent_d[sel_idx[p]].valid = 1'b0;
    end
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      if (disp_acc[s]) begin
        ent_d[disp_idx[s]] = disp_ent[s];
`ifdef AGE_SELECT_EN
        ent_d[disp_idx[s]].age = stamp;
        stamp = stamp + CW'(1);
`endif
      end
    end
    if (flush_i) begin
      for (int e = 0; e < RS_DEPTH; e++) ent_d[e].valid = 1'b0;
    end
  end

  // Entry array and occupancy registers; reset clears immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < RS_DEPTH; e++) ent_q[e] <= '0;
      count_q <= '0;
    end else begin
      for (int e = 0; e < RS_DEPTH; e++) ent_q[e] <= ent_d[e];
      if (flush_i) count_q <= '0;
      else         count_q <= count_q + acc_n - fire_n;
    end
  end

`ifdef AGE_SELECT_EN
  // Wrapping dispatch counter that stamps each accepted op in arrival order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        age_ctr_q <= '0;
    else if (flush_i) age_ctr_q <= '0;
    else              age_ctr_q <= age_ctr_q + acc_n;
  end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed bench for issue_queue with a queue-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_issue_queue;
  localparam int W = 32, NP = 64, ROBS = 64, OPW = 4, DEPTH = 16, DW = 2, IW = 2, WBW = 3;
  localparam int PT = 6, RB = 6, CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  int            checks = 0;
  int            failures = 0;

  issue_queue_if #(.WORD_SIZE(W), .NUM_P_REGS(NP), .ROB_SIZE(ROBS), .ALU_OP_SIZE(OPW),
                   .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW), .WB_WIDTH(WBW)) bus ();

  issue_queue #(.WORD_SIZE(W), .NUM_P_REGS(NP), .ROB_SIZE(ROBS), .ALU_OP_SIZE(OPW),
                .RS_DEPTH(DEPTH), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW), .WB_WIDTH(WBW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .iq(bus), .count_o(count), .full_o(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: a bag of waiting ops ----------------
  bit           m_vld [DEPTH];
  logic [PT-1:0] m_dest [DEPTH], m_t1 [DEPTH], m_t2 [DEPTH];
  bit           m_r1 [DEPTH], m_r2 [DEPTH], m_ui [DEPTH];
  logic [W-1:0] m_v1 [DEPTH], m_v2 [DEPTH], m_imm [DEPTH];
  logic [OPW-1:0] m_op [DEPTH];
  logic [RB-1:0] m_rob [DEPTH];
  int           m_seq [DEPTH];
  int           seq_ctr = 0;

  function automatic bit m_elig(input int e);
    return m_vld[e] && m_r1[e] && (m_ui[e] || m_r2[e]);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int e = 0; e < DEPTH; e++) n += int'(m_vld[e]);
    return n;
  endfunction

  function automatic bit wb_hit(input logic [PT-1:0] tag, output logic [W-1:0] val);
    val = '0;
    for (int w = 0; w < WBW; w++) begin
      if (bus.wb_valid_i[w] && bus.wb_tag_i[w*PT +: PT] == tag) begin
        val = bus.wb_val_i[w*W +: W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Compare every cycle, then advance the model with the inputs held for the coming edge.
  always @(negedge clk) begin
    int sel [IW];
    bit sv [IW];
    bit taken [DEPTH];
    bit freed [DEPTH];
    bit exp_v;
    int e_new;
    logic [W-1:0] v;
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) m_vld[e] = 1'b0;
      seq_ctr = 0;
      chk("m_rst_count", count, 0);
      chk("m_rst_ivld", bus.iss_valid_o, 0);
      chk("m_rst_rdy", bus.disp_ready_o, 1);
    end else begin
      for (int p = 0; p < IW; p++) begin
        sv[p] = 1'b0;
        sel[p] = 0;
        for (int e = 0; e < DEPTH; e++) begin
          if (m_elig(e) && !(p == 1 && sv[0] && sel[0] == e)) begin
`ifdef AGE_SELECT_EN
            if (!sv[p] || m_seq[e] < m_seq[sel[p]]) begin sv[p] = 1'b1; sel[p] = e; end
`else
            if (!sv[p]) begin sv[p] = 1'b1; sel[p] = e; end
`endif
          end
        end
      end
      chk("m_count", count, m_count());
      chk("m_full", full, m_count() == DEPTH);
      chk("m_disp_ready", bus.disp_ready_o, (DEPTH - m_count()) >= DW);
      for (int p = 0; p < IW; p++) begin
        exp_v = sv[p] && !flush;
        chk($sformatf("m_iss_valid%0d", p), bus.iss_valid_o[p], exp_v);
        if (exp_v) begin
          chk($sformatf("m_data0_%0d", p), bus.iss_data0_o[p*W +: W], m_v1[sel[p]]);
          chk($sformatf("m_data1_%0d", p), bus.iss_data1_o[p*W +: W],
              m_ui[sel[p]] ? m_imm[sel[p]] : m_v2[sel[p]]);
          chk($sformatf("m_op%0d", p), bus.iss_alu_op_o[p*OPW +: OPW], m_op[sel[p]]);
          chk($sformatf("m_dest%0d", p), bus.iss_dest_o[p*PT +: PT], m_dest[sel[p]]);
          chk($sformatf("m_rob%0d", p), bus.iss_rob_idx_o[p*RB +: RB], m_rob[sel[p]]);
        end
      end
      // state advance
      if (flush) begin
        for (int e = 0; e < DEPTH; e++) m_vld[e] = 1'b0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          freed[e] = 1'b0;
          taken[e] = m_vld[e];
        end
        for (int p = 0; p < IW; p++) if (sv[p] && bus.iss_ready_i[p]) freed[sel[p]] = 1'b1;
        for (int e = 0; e < DEPTH; e++) begin
          if (m_vld[e] && !m_r1[e] && wb_hit(m_t1[e], v)) begin m_r1[e] = 1'b1; m_v1[e] = v; end
          if (m_vld[e] && !m_ui[e] && !m_r2[e] && wb_hit(m_t2[e], v)) begin m_r2[e] = 1'b1; m_v2[e] = v; end
        end
        if ((DEPTH - m_count()) >= DW) begin
          for (int s = 0; s < DW; s++) begin
            if (bus.disp_valid_i[s]) begin
              e_new = -1;
              for (int e = DEPTH - 1; e >= 0; e--) if (!taken[e]) e_new = e;
              taken[e_new] = 1'b1;
              m_vld[e_new]  = 1'b1;
              m_dest[e_new] = bus.disp_dest_i[s*PT +: PT];
              m_t1[e_new]   = bus.disp_rs1_i[s*PT +: PT];
              m_t2[e_new]   = bus.disp_rs2_i[s*PT +: PT];
              m_ui[e_new]   = bus.disp_use_imm_i[s];
              m_imm[e_new]  = bus.disp_imm_i[s*W +: W];
              m_op[e_new]   = bus.disp_alu_op_i[s*OPW +: OPW];
              m_rob[e_new]  = bus.disp_rob_idx_i[s*RB +: RB];
              m_seq[e_new]  = seq_ctr++;
              m_r1[e_new]   = bus.disp_rs1_rdy_i[s];
              m_v1[e_new]   = bus.disp_rs1_val_i[s*W +: W];
              if (!m_r1[e_new] && wb_hit(m_t1[e_new], v)) begin m_r1[e_new] = 1'b1; m_v1[e_new] = v; end
              m_r2[e_new]   = bus.disp_rs2_rdy_i[s];
              m_v2[e_new]   = bus.disp_rs2_val_i[s*W +: W];
              if (!m_r2[e_new] && wb_hit(m_t2[e_new], v)) begin m_r2[e_new] = 1'b1; m_v2[e_new] = v; end
            end
          end
        end
        for (int e = 0; e < DEPTH; e++) if (freed[e]) m_vld[e] = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.disp_valid_i = '0;
    bus.wb_valid_i   = '0;
    flush            = 1'b0;
  endtask

  task automatic set_slot(input int s, input int dest, input int t1, input bit r1, input int v1,
                          input int t2, input bit r2, input int v2, input bit ui, input int imm,
                          input int op, input int rob);
    bus.disp_dest_i[s*PT +: PT]     = dest[PT-1:0];
    bus.disp_rs1_i[s*PT +: PT]      = t1[PT-1:0];
    bus.disp_rs1_rdy_i[s]           = r1;
    bus.disp_rs1_val_i[s*W +: W]    = v1;
    bus.disp_rs2_i[s*PT +: PT]      = t2[PT-1:0];
    bus.disp_rs2_rdy_i[s]           = r2;
    bus.disp_rs2_val_i[s*W +: W]    = v2;
    bus.disp_use_imm_i[s]           = ui;
    bus.disp_imm_i[s*W +: W]        = imm;
    bus.disp_alu_op_i[s*OPW +: OPW] = op[OPW-1:0];
    bus.disp_rob_idx_i[s*RB +: RB]  = rob[RB-1:0];
  endtask

  task automatic set_wb(input int w, input int tag, input int val);
    bus.wb_valid_i[w]         = 1'b1;
    bus.wb_tag_i[w*PT +: PT]  = tag[PT-1:0];
    bus.wb_val_i[w*W +: W]    = val;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.disp_valid_i = '0; bus.disp_dest_i = '0; bus.disp_rs1_i = '0; bus.disp_rs2_i = '0;
    bus.disp_rs1_rdy_i = '0; bus.disp_rs2_rdy_i = '0; bus.disp_rs1_val_i = '0;
    bus.disp_rs2_val_i = '0; bus.disp_imm_i = '0; bus.disp_use_imm_i = '0;
    bus.disp_alu_op_i = '0; bus.disp_rob_idx_i = '0;
    bus.wb_valid_i = '0; bus.wb_tag_i = '0; bus.wb_val_i = '0;
    bus.iss_ready_i = 2'b11;

    // reset state
    look(); look();
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_disp_ready", bus.disp_ready_o, 1);
    chk("rst_iss_valid", bus.iss_valid_o, 0);
    chk("rst_data0", bus.iss_data0_o, 0);
    chk("rst_data1", bus.iss_data1_o, 0);
    step(); rst = 1'b0;

    // two all-ready ops: r5=r1+r2 (3,4) and r6=r1+imm 10
    step();
    set_slot(0, 5, 1, 1, 3, 2, 1, 4, 0, 0, 1, 0);
    set_slot(1, 6, 1, 1, 3, 0, 0, 0, 1, 10, 2, 1);
    bus.disp_valid_i = 2'b11;
    look(); chk("t1_count_before", count, 0);
    step(); idle(); look();
    chk("t1_valid", bus.iss_valid_o, 2'b11);
    chk("t1_data0", bus.iss_data0_o, {32'd3, 32'd3});
    chk("t1_data1", bus.iss_data1_o, {32'd10, 32'd4});
    chk("t1_dest", bus.iss_dest_o, {6'd6, 6'd5});
    chk("t1_count", count, 2);
    step(); look();
    chk("t1_count_after", count, 0);
    chk("t1_valid_after", bus.iss_valid_o, 0);

    // rs1 tag 7 woken two cycles after dispatch
    step(); set_slot(0, 10, 7, 0, 0, 0, 0, 0, 1, 1, 3, 2); bus.disp_valid_i = 2'b01;
    step(); idle(); look(); chk("t2_wait", bus.iss_valid_o, 0);
    step(); set_wb(0, 7, 32'hDEAD); look(); chk("t2_wb_cycle", bus.iss_valid_o, 0);
    step(); idle(); look();
    chk("t2_valid", bus.iss_valid_o, 2'b01);
    chk("t2_data0", bus.iss_data0_o[31:0], 32'hDEAD);
    step(); look(); chk("t2_count_after", count, 0);

    // tag 0 is an ordinary tag
    step(); set_slot(0, 12, 0, 0, 0, 0, 0, 0, 1, 5, 6, 7); bus.disp_valid_i = 2'b01;
    step(); idle(); set_wb(1, 0, 123);
    step(); idle(); look();
    chk("t0_valid", bus.iss_valid_o, 2'b01);
    chk("t0_data0", bus.iss_data0_o[31:0], 123);

    // rs2 tag 9 woken in the dispatch cycle; lowest wb port wins
    step(); idle();
    set_slot(0, 11, 3, 1, 1, 9, 0, 0, 0, 0, 4, 3); bus.disp_valid_i = 2'b01;
    set_wb(0, 9, 55); set_wb(2, 9, 99);
    step(); idle(); look();
    chk("t3_valid", bus.iss_valid_o, 2'b01);
    chk("t3_data1", bus.iss_data1_o[31:0], 55);
    step(); look(); chk("t3_count_after", count, 0);

    // fill all 16 entries with waiting ops
    for (int i = 0; i < 8; i++) begin
      step();
      set_slot(0, 2*i,   20 + 2*i, 0, 0, 0, 0, 0, 1, i, 1, 2*i);
      set_slot(1, 2*i+1, 21 + 2*i, 0, 0, 0, 0, 0, 1, i, 1, 2*i+1);
      bus.disp_valid_i = 2'b11;
    end
    step(); idle(); look();
    chk("t4_count16", count, 16);
    chk("t4_full", full, 1);
    chk("t4_ready0", bus.disp_ready_o, 0);
    step(); set_slot(0, 40, 40, 1, 1, 0, 0, 0, 1, 0, 0, 0); set_slot(1, 41, 41, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    bus.disp_valid_i = 2'b11;
    step(); set_wb(0, 20, 7); look(); chk("t4_dropped", count, 16);
    step(); bus.wb_valid_i = '0; look();
    chk("t4_woke", bus.iss_valid_o, 2'b01);
    chk("t4_woke_data", bus.iss_data0_o[31:0], 7);
    step(); look();
    chk("t4_count15", count, 15);
    chk("t4_ready_at15", bus.disp_ready_o, 0);
    chk("t4_full_at15", full, 0);
    step(); bus.disp_valid_i = '0; set_wb(0, 21, 8); look(); chk("t4_still15", count, 15);
    step(); bus.wb_valid_i = '0; flush = 1'b1; look();
    chk("t4_flush_valid", bus.iss_valid_o, 0);
    step(); flush = 1'b0; look(); chk("t4_flush_count", count, 0);

    // dispatch during flush is discarded
    step(); set_slot(0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1); bus.disp_valid_i = 2'b11; flush = 1'b1;
    step(); idle(); look();
    chk("t5_flush_disp", count, 0);

    // hold under backpressure, then release while dispatching into other entries
    step(); bus.iss_ready_i = 2'b00;
    set_slot(0, 1, 1, 1, 11, 2, 1, 12, 0, 0, 5, 4);
    set_slot(1, 2, 3, 1, 13, 4, 1, 14, 0, 0, 6, 5);
    bus.disp_valid_i = 2'b11;
    step(); idle();
    for (int k = 0; k < 3; k++) begin
      look();
      chk("t6_hold_valid", bus.iss_valid_o, 2'b11);
      chk("t6_hold_data0", bus.iss_data0_o, {32'd13, 32'd11});
      chk("t6_hold_data1", bus.iss_data1_o, {32'd14, 32'd12});
      step();
    end
    bus.iss_ready_i = 2'b11;
    set_slot(0, 30, 50, 0, 0, 0, 0, 0, 1, 0, 7, 8);
    set_slot(1, 31, 51, 0, 0, 0, 0, 0, 1, 0, 7, 9);
    bus.disp_valid_i = 2'b11;
    look(); chk("t6_release_count", count, 2);
    step(); idle(); look();
    chk("t6_refill_count", count, 2);
    chk("t6_refill_valid", bus.iss_valid_o, 0);
    step(); set_wb(0, 50, 100); set_wb(1, 51, 101);
    step(); idle(); look();
    chk("t6_wake_data0", bus.iss_data0_o, {32'd101, 32'd100});
    step(); look(); chk("t6_empty", count, 0);

    // reset in the middle of a stalled issue
    step(); set_slot(0, 3, 1, 1, 9, 2, 1, 9, 0, 0, 1, 1); set_slot(1, 4, 1, 1, 9, 2, 1, 9, 0, 0, 1, 2);
    bus.disp_valid_i = 2'b11;
    step(); idle(); bus.iss_ready_i = 2'b00; #2 rst = 1'b1;
    look();
    chk("t7_rst_count", count, 0);
    chk("t7_rst_valid", bus.iss_valid_o, 0);
    step(); rst = 1'b0; bus.iss_ready_i = 2'b11;
    look(); chk("t7_after", count, 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
